// File: rtl/cpu_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_if : signal bundle between the hardwired control unit and the
// datapath (IR, Z flag, ALU, register file, memory port).
//
//   ir        opcode from the instruction register (datapath -> control)
//   z         accumulator zero flag                (datapath -> control)
//   mem_rdy   memory completes current access      (memory   -> control)
//   alus      ALU function code                    (control  -> ALU)
//   bsel      internal bus source select           (control  -> datapath)
//   *load/pcinc register strobes                   (control  -> datapath)
//   read/write memory request                      (control  -> memory)
//   halt      CPU stopped                          (control  -> system)
//   dbg_state current control state, for observation only
//
// Memory handshake: read or write is held high as a request; the access
// completes on the first rising clock edge at which mem_rdy is also high.
// The request drops on the following cycle. mem_rdy is ignored while no
// request is being made.
// ---------------------------------------------------------------------------
interface cpu_ctrl_if #(
  parameter int OPW   = 8,
  parameter int ALUSW = 7
);
  logic [OPW-1:0]   ir;
  logic             z;
  logic             mem_rdy;
  logic [ALUSW-1:0] alus;
  logic [2:0]       bsel;
  logic             arload;
  logic             pcload;
  logic             pcinc;
  logic             drload;
  logic             irload;
  logic             acload;
  logic             rload;
  logic             zload;
  logic             read;
  logic             write;
  logic             halt;
  logic [3:0]       dbg_state;

  // Control unit side
  modport master (
    input  ir, z, mem_rdy,
    output alus, bsel, arload, pcload, pcinc, drload, irload, acload,
           rload, zload, read, write, halt, dbg_state
  );

  // Datapath / environment side
  modport slave (
    output ir, z, mem_rdy,
    input  alus, bsel, arload, pcload, pcinc, drload, irload, acload,
           rload, zload, read, write, halt, dbg_state
  );
endinterface

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl : hardwired control unit for the 8-bit accumulator CPU.
// Sequences fetch / decode / execute and drives the ALU function code,
// register strobes, bus source select and memory requests.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset (forces START, zeroes all outputs)
//   bus  cpu_ctrl_if.master : ir, z, mem_rdy in; alus, bsel, strobes,
//        read, write, halt, dbg_state out
//
// All outputs are combinational from the current state, ir, z and mem_rdy.
// ---------------------------------------------------------------------------
module cpu_ctrl #(
  parameter int OPW   = 8,
  parameter int ALUSW = 7
) (
  input  logic        clk,
  input  logic        rst,
  cpu_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_FETCH3 = 4'd3,
    S_DECODE = 4'd4,
    S_EXEC   = 4'd5,
    S_ADDR1  = 4'd6,
    S_ADDR2  = 4'd7,
    S_SKIP   = 4'd8,
    S_LD1    = 4'd9,
    S_LD2    = 4'd10,
    S_ST1    = 4'd11,
    S_ST2    = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  // Opcodes
  localparam logic [OPW-1:0] OP_LDAC = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_STAC = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_MVAC = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_MOVR = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_JUMP = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_JMPZ = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_JPNZ = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_AND  = OPW'(8'h0A);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8'h0B);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(8'h0C);
  localparam logic [OPW-1:0] OP_INAC = OPW'(8'h0D);
  localparam logic [OPW-1:0] OP_CLAC = OPW'(8'h0E);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(8'h0F);
  localparam logic [OPW-1:0] OP_HALT = OPW'(8'h10);

  // ALU function codes
  localparam logic [ALUSW-1:0] ALU_IDLE = ALUSW'(0);
  localparam logic [ALUSW-1:0] ALU_ADD  = ALUSW'(1);
  localparam logic [ALUSW-1:0] ALU_SUB  = ALUSW'(2);
  localparam logic [ALUSW-1:0] ALU_AND  = ALUSW'(3);
  localparam logic [ALUSW-1:0] ALU_OR   = ALUSW'(4);
  localparam logic [ALUSW-1:0] ALU_XOR  = ALUSW'(5);
  localparam logic [ALUSW-1:0] ALU_INC  = ALUSW'(6);
  localparam logic [ALUSW-1:0] ALU_CLR  = ALUSW'(7);
  localparam logic [ALUSW-1:0] ALU_NOT  = ALUSW'(8);
  localparam logic [ALUSW-1:0] ALU_PASS = ALUSW'(9);

  // Bus sources
  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_PC   = 3'd1;
  localparam logic [2:0] B_DR   = 3'd2;
  localparam logic [2:0] B_AC   = 3'd3;
  localparam logic [2:0] B_R    = 3'd4;
  localparam logic [2:0] B_MEM  = 3'd5;

  state_t           r_state;
  state_t           w_next;
  logic [ALUSW-1:0] w_alus;
  logic [ALUSW-1:0] w_alu_code;
  logic [2:0]       w_bsel;
  logic             w_arload, w_pcload, w_pcinc, w_drload, w_irload;
  logic             w_acload, w_rload, w_zload, w_read, w_write, w_halt;

  // ALU code for the register/accumulator operations; IR stays stable
  // from DECODE through EXEC, so it is read directly.
  always_comb begin
    w_alu_code = ALU_IDLE;
    case (bus.ir)
      OP_MOVR: w_alu_code = ALU_PASS;
      OP_ADD:  w_alu_code = ALU_ADD;
      OP_SUB:  w_alu_code = ALU_SUB;
      OP_AND:  w_alu_code = ALU_AND;
      OP_OR:   w_alu_code = ALU_OR;
      OP_XOR:  w_alu_code = ALU_XOR;
      OP_INAC: w_alu_code = ALU_INC;
      OP_CLAC: w_alu_code = ALU_CLR;
      OP_NOT:  w_alu_code = ALU_NOT;
      default: w_alu_code = ALU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_START;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_alus   = ALU_IDLE;
    w_bsel   = B_NONE;
    w_arload = 1'b0;
    w_pcload = 1'b0;
    w_pcinc  = 1'b0;
    w_drload = 1'b0;
    w_irload = 1'b0;
    w_acload = 1'b0;
    w_rload  = 1'b0;
    w_zload  = 1'b0;
    w_read   = 1'b0;
    w_write  = 1'b0;
    w_halt   = 1'b0;

    case (r_state)
      S_START: w_next = S_FETCH1;

      S_FETCH1: begin
        w_bsel   = B_PC;
        w_arload = 1'b1;
        w_next   = S_FETCH2;
      end

      // Instruction word read; DR captures and PC advances only on the
      // completing cycle.
      S_FETCH2: begin
        w_read = 1'b1;
        w_bsel = B_MEM;
        if (bus.mem_rdy) begin
          w_drload = 1'b1;
          w_pcinc  = 1'b1;
          w_next   = S_FETCH3;
        end
      end

      S_FETCH3: begin
        w_bsel   = B_DR;
        w_irload = 1'b1;
        w_arload = 1'b1;
        w_next   = S_DECODE;
      end

      S_DECODE: begin
        case (bus.ir)
          OP_LDAC, OP_STAC, OP_JUMP: w_next = S_ADDR1;
          OP_JMPZ: w_next = bus.z ? S_ADDR1 : S_SKIP;
          OP_JPNZ: w_next = bus.z ? S_SKIP : S_ADDR1;
          OP_MVAC, OP_MOVR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_INAC, OP_CLAC, OP_NOT: w_next = S_EXEC;
          OP_HALT: w_next = S_HALT;
          default: w_next = S_FETCH1;
        endcase
      end

      S_EXEC: begin
        case (bus.ir)
          OP_MVAC: begin
            w_bsel  = B_AC;
            w_rload = 1'b1;
          end
          OP_MOVR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            w_bsel   = B_R;
            w_alus   = w_alu_code;
            w_acload = 1'b1;
            w_zload  = 1'b1;
          end
          // Unary accumulator ops take no bus operand.
          OP_INAC, OP_CLAC, OP_NOT: begin
            w_alus   = w_alu_code;
            w_acload = 1'b1;
            w_zload  = 1'b1;
          end
          default: ;
        endcase
        w_next = S_FETCH1;
      end

      // Address word read, same completion rule as the instruction fetch.
      S_ADDR1: begin
        w_read = 1'b1;
        w_bsel = B_MEM;
        if (bus.mem_rdy) begin
          w_drload = 1'b1;
          w_pcinc  = 1'b1;
          w_next   = S_ADDR2;
        end
      end

      S_ADDR2: begin
        w_bsel = B_DR;
        case (bus.ir)
          OP_LDAC: begin
            w_arload = 1'b1;
            w_next   = S_LD1;
          end
          OP_STAC: begin
            w_arload = 1'b1;
            w_next   = S_ST1;
          end
          OP_JUMP, OP_JMPZ, OP_JPNZ: begin
            w_pcload = 1'b1;
            w_next   = S_FETCH1;
          end
          default: w_next = S_FETCH1;
        endcase
      end

      // Branch not taken: step PC over the unused address word.
      S_SKIP: begin
        w_pcinc = 1'b1;
        w_next  = S_FETCH1;
      end

      S_LD1: begin
        w_read = 1'b1;
        w_bsel = B_MEM;
        if (bus.mem_rdy) begin
          w_drload = 1'b1;
          w_next   = S_LD2;
        end
      end

      S_LD2: begin
        w_bsel   = B_DR;
        w_alus   = ALU_PASS;
        w_acload = 1'b1;
        w_zload  = 1'b1;
        w_next   = S_FETCH1;
      end

      S_ST1: begin
        w_bsel   = B_AC;
        w_drload = 1'b1;
        w_next   = S_ST2;
      end

      S_ST2: begin
        w_bsel  = B_DR;
        w_write = 1'b1;
        if (bus.mem_rdy) w_next = S_FETCH1;
      end

      S_HALT: w_halt = 1'b1;

      default: w_next = S_START;
    endcase

    // Reset kills every request and strobe immediately, without waiting
    // for the state register to be cleared.
    if (rst) begin
      w_alus   = ALU_IDLE;
      w_bsel   = B_NONE;
      w_arload = 1'b0;
      w_pcload = 1'b0;
      w_pcinc  = 1'b0;
      w_drload = 1'b0;
      w_irload = 1'b0;
      w_acload = 1'b0;
      w_rload  = 1'b0;
      w_zload  = 1'b0;
      w_read   = 1'b0;
      w_write  = 1'b0;
      w_halt   = 1'b0;
    end
  end

  assign bus.alus      = w_alus;
  assign bus.bsel      = w_bsel;
  assign bus.arload    = w_arload;
  assign bus.pcload    = w_pcload;
  assign bus.pcinc     = w_pcinc;
  assign bus.drload    = w_drload;
  assign bus.irload    = w_irload;
  assign bus.acload    = w_acload;
  assign bus.rload     = w_rload;
  assign bus.zload     = w_zload;
  assign bus.read      = w_read;
  assign bus.write     = w_write;
  assign bus.halt      = w_halt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl : self-checking bench for cpu_ctrl.
// An instruction-level model expands each opcode into the list of per-cycle
// control words it must produce (with the mem_rdy value to drive that
// cycle); the driver plays the list, the compare process checks every cycle.
// Control word layout: {alus[6:0], bsel[2:0], arload, pcload, pcinc,
// drload, irload, acload, rload, zload, read, write, halt}.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl;
  localparam int W = 21;

  localparam logic [10:0] F_AR  = 11'h400;
  localparam logic [10:0] F_PCL = 11'h200;
  localparam logic [10:0] F_PCI = 11'h100;
  localparam logic [10:0] F_DRL = 11'h080;
  localparam logic [10:0] F_IRL = 11'h040;
  localparam logic [10:0] F_ACL = 11'h020;
  localparam logic [10:0] F_RL  = 11'h010;
  localparam logic [10:0] F_ZL  = 11'h008;
  localparam logic [10:0] F_RD  = 11'h004;
  localparam logic [10:0] F_WR  = 11'h002;
  localparam logic [10:0] F_HL  = 11'h001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_ctrl_if bus ();
  cpu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [W-1:0] got;
  assign got = {bus.alus, bus.bsel, bus.arload, bus.pcload, bus.pcinc,
                bus.drload, bus.irload, bus.acload, bus.rload, bus.zload,
                bus.read, bus.write, bus.halt};

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] plan_q[$];
  bit           plan_rdy[$];

  task automatic check(input string nm, input logic [W-1:0] g, input logic [W-1:0] x);
    n_checks++;
    if (g === x) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, g, x);
  endtask

  // ---------------- model ----------------
  function automatic logic [W-1:0] ov(input int a, input int b, input logic [10:0] f);
    logic [6:0] a7;
    logic [2:0] b3;
    a7 = a[6:0];
    b3 = b[2:0];
    return {a7, b3, f};
  endfunction

  function automatic int alu_code(input logic [7:0] op);
    case (op)
      8'h04: return 9;
      8'h08: return 1;
      8'h09: return 2;
      8'h0A: return 3;
      8'h0B: return 4;
      8'h0C: return 5;
      8'h0D: return 6;
      8'h0E: return 7;
      8'h0F: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic plan(input bit r, input logic [W-1:0] e);
    plan_rdy.push_back(r);
    plan_q.push_back(e);
  endtask

  // n not-ready cycles of a memory read, then the completing cycle
  task automatic mem_wait(input int n, input logic [10:0] done_flags);
    for (int i = 0; i < n; i++) plan(1'b0, ov(0, 5, F_RD));
    plan(1'b1, ov(0, 5, F_RD | done_flags));
  endtask

  task automatic build(input logic [7:0] op, input logic zv, input int wf,
                       input int wa, input int wm, input int nh);
    bit takes_addr;
    takes_addr = (op == 8'h01) || (op == 8'h02) || (op == 8'h05) ||
                 (op == 8'h06 && zv) || (op == 8'h07 && !zv);
    plan(rnd(), ov(0, 1, F_AR));
    mem_wait(wf, F_DRL | F_PCI);
    plan(rnd(), ov(0, 2, F_IRL | F_AR));
    plan(rnd(), ov(0, 0, 11'h000));
    if (takes_addr) begin
      mem_wait(wa, F_DRL | F_PCI);
      if (op == 8'h01 || op == 8'h02) plan(rnd(), ov(0, 2, F_AR));
      else                            plan(rnd(), ov(0, 2, F_PCL));
      if (op == 8'h01) begin
        mem_wait(wm, F_DRL);
        plan(rnd(), ov(9, 2, F_ACL | F_ZL));
      end else if (op == 8'h02) begin
        plan(rnd(), ov(0, 3, F_DRL));
        for (int i = 0; i < wm; i++) plan(1'b0, ov(0, 2, F_WR));
        plan(1'b1, ov(0, 2, F_WR));
      end
    end else if (op == 8'h06 || op == 8'h07) begin
      plan(rnd(), ov(0, 0, F_PCI));
    end else if (op == 8'h03) begin
      plan(rnd(), ov(0, 3, F_RL));
    end else if (op == 8'h04 || (op >= 8'h08 && op <= 8'h0F)) begin
      plan(rnd(), ov(alu_code(op), (op <= 8'h0C) ? 4 : 0, F_ACL | F_ZL));
    end else if (op == 8'h10) begin
      for (int i = 0; i < nh; i++) plan(rnd(), ov(0, 0, F_HL));
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_plan(input logic [7:0] op, input logic zv);
    bit first;
    first = 1'b1;
    while (plan_q.size() > 0) begin
      @(negedge clk);
      if (first) begin
        bus.ir = op;
        bus.z  = zv;
        first  = 1'b0;
      end
      bus.mem_rdy = plan_rdy.pop_front();
      exp_q.push_back(plan_q.pop_front());
    end
  endtask

  task automatic do_instr(input logic [7:0] op, input logic zv, input int wf,
                          input int wa, input int wm);
    build(op, zv, wf, wa, wm, 0);
    run_plan(op, zv);
  endtask

  // Drive rst mid-cycle; outputs must be all zero right away.
  task automatic step_rst(input logic r);
    @(negedge clk);
    rst = r;
    exp_q.push_back('0);
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] cmp_e;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      check("ctrl_word", got, cmp_e);
      check("rd_wr_excl", W'(bus.read & bus.write), W'(0));
      check("bsel_range", W'(bus.bsel > 3'd5), W'(0));
      check("alus_needs_acload", W'((bus.alus != 7'd0) && !bus.acload), W'(0));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.ir = 8'h00;
    bus.z = 1'b0;
    bus.mem_rdy = 1'b1;

    step_rst(1'b1);
    step_rst(1'b1);
    step_rst(1'b0);            // START cycle after release

    // Pin the model against hand-computed words.
    build(8'h08, 1'b0, 0, 0, 0, 0);
    check("pin_add_len", W'(plan_q.size()), W'(5));
    check("pin_add_exec", plan_q[4], W'(21'h06028));
    check("pin_fetch1", plan_q[0], W'(21'h00C00));
    run_plan(8'h08, 1'b0);

    build(8'h01, 1'b0, 0, 0, 0, 0);
    check("pin_ldac_len", W'(plan_q.size()), W'(8));
    check("pin_ld1_rdy", plan_q[6], W'(21'h02884));
    check("pin_ld2", plan_q[7], W'(21'h25028));
    run_plan(8'h01, 1'b0);

    build(8'h01, 1'b0, 1, 0, 3, 0);
    check("pin_ldac_wait_len", W'(plan_q.size()), W'(12));
    run_plan(8'h01, 1'b0);

    build(8'h06, 1'b0, 0, 0, 0, 0);
    check("pin_jmpz_skip", plan_q[4], W'(21'h00100));
    run_plan(8'h06, 1'b0);

    build(8'h10, 1'b0, 0, 0, 0, 22);
    check("pin_halt_len", W'(plan_q.size()), W'(26));
    plan_q.delete();
    plan_rdy.delete();

    // Branches, jump, store
    do_instr(8'h06, 1'b1, 0, 2, 0);
    do_instr(8'h07, 1'b0, 1, 0, 0);
    do_instr(8'h07, 1'b1, 0, 0, 0);
    do_instr(8'h05, 1'b0, 0, 1, 0);
    do_instr(8'h02, 1'b0, 0, 0, 2);
    do_instr(8'h02, 1'b1, 2, 1, 0);

    // Register / ALU operations
    for (int op = 3; op <= 15; op++) begin
      if (op != 5 && op != 6 && op != 7)
        do_instr(8'(op), 1'(op & 1), op % 2, 0, 0);
    end

    // Unused opcodes behave as NOP
    do_instr(8'h00, 1'b0, 0, 0, 0);
    do_instr(8'h3C, 1'b1, 0, 0, 0);
    do_instr(8'hFF, 1'b0, 1, 0, 0);

    // Reset during an instruction-fetch wait
    plan(rnd(), ov(0, 1, F_AR));
    plan(1'b0, ov(0, 5, F_RD));
    plan(1'b0, ov(0, 5, F_RD));
    run_plan(8'h00, 1'b0);
    step_rst(1'b1);
    step_rst(1'b0);
    do_instr(8'h0E, 1'b0, 0, 0, 0);

    // Reset during a store wait: drop the completing ST2 cycle
    build(8'h02, 1'b0, 0, 0, 3, 0);
    void'(plan_q.pop_back());
    void'(plan_rdy.pop_back());
    run_plan(8'h02, 1'b0);
    step_rst(1'b1);
    step_rst(1'b0);
    do_instr(8'h09, 1'b0, 0, 0, 0);

    // Halt, held, then cleared by reset; NOP-like opcode afterwards
    build(8'h10, 1'b0, 0, 0, 0, 22);
    run_plan(8'h10, 1'b0);
    step_rst(1'b1);
    step_rst(1'b0);
    do_instr(8'h3C, 1'b0, 0, 0, 0);
    do_instr(8'h0D, 1'b0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
